// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the direct-mapped write-through cache.
package cache_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_RESP  = 2'd2,
    S_WRITE = 2'd3
  } state_e;

  // Byte-offset bits inside one word.
  function automatic int bo_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Index bits selecting a line.
  function automatic int idx_bits(input int lines);
    return $clog2(lines);
  endfunction

  // Word-offset bits selecting a word inside a line.
  function automatic int wo_bits(input int words);
    return $clog2(words);
  endfunction

  // Remaining high address bits form the tag.
  function automatic int tag_bits(input int addr_w, input int data_w,
                                  input int lines, input int words);
    return addr_w - idx_bits(lines) - wo_bits(words) - bo_bits(data_w);
  endfunction

endpackage

// File: rtl/cache_line_ram.sv
// Tag/valid and data storage: asynchronous read, one synchronous write port.
module cache_line_ram
  import cache_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 26,
  parameter int LINES  = 64,
  parameter int WORDS  = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [idx_bits(LINES)-1:0]    rd_idx_i,
  input  logic [wo_bits(WORDS)-1:0]     rd_wo_i,
  output logic [TAG_W-1:0]              rd_tag_o,
  output logic                          rd_valid_o,
  output logic [DATA_W-1:0]             rd_data_o,
  input  logic [idx_bits(LINES)-1:0]    wr_idx_i,
  input  logic [wo_bits(WORDS)-1:0]     wr_wo_i,
  input  logic [DATA_W-1:0]             wr_data_i,
  input  logic                          data_we_i,
  input  logic                          tag_we_i,
  input  logic [TAG_W-1:0]              wr_tag_i,
  input  logic                          inval_i
);

  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES*WORDS];
  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  valid_d;

  // Valid bit update: a miss invalidates the line, a completed refill validates it.
  always_comb begin
    valid_d = valid_q;
    if (inval_i)  valid_d[wr_idx_i] = 1'b0;
    if (tag_we_i) valid_d[wr_idx_i] = 1'b1;
  end

  // Valid bits are the only reset state in the arrays.
  always_ff @(posedge clk_i) begin
    if (rst_i) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  // Tag and data arrays are written without reset.
  always_ff @(posedge clk_i) begin
    if (tag_we_i)  tag_q[wr_idx_i] <= wr_tag_i;
    if (data_we_i) data_q[{wr_idx_i, wr_wo_i}] <= wr_data_i;
  end

  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_data_o  = data_q[{rd_idx_i, rd_wo_i}];

endmodule

// File: rtl/cache_dm_wt.sv
// Direct-mapped, write-through, no-write-allocate cache with burst line refill.
module cache_dm_wt
  import cache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINES  = 64,
  parameter int WORDS  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam int BO   = bo_bits(DATA_W);
  localparam int IDX  = idx_bits(LINES);
  localparam int WO   = wo_bits(WORDS);
  localparam int TAG  = tag_bits(ADDR_W, DATA_W, LINES, WORDS);
  localparam int WA_W = ADDR_W - BO;
  localparam logic [WO-1:0] LAST_WO = WO'(WORDS - 1);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_e            state_q, state_d;
  logic [WA_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [WO-1:0]     cnt_q, cnt_d;
  logic [31:0]       hit_q, hit_d, miss_q, miss_d;

  logic [TAG-1:0]    req_tag, q_tag, rd_tag;
  logic [IDX-1:0]    req_idx, q_idx, rd_idx, wr_idx;
  logic [WO-1:0]     req_wo, q_wo, rd_wo, wr_wo;
  logic [DATA_W-1:0] rd_data, wr_data;
  logic              rd_valid, lookup_hit, data_we, tag_we, inval;
  logic              unused_bits;

  // Byte lanes inside a word are not addressed by this cache.
  assign unused_bits = ^req_addr[BO-1:0];

  assign req_tag = req_addr[ADDR_W-1 -: TAG];
  assign req_idx = req_addr[BO+WO +: IDX];
  assign req_wo  = req_addr[BO +: WO];
  assign q_tag   = waddr_q[WA_W-1 -: TAG];
  assign q_idx   = waddr_q[WO +: IDX];
  assign q_wo    = waddr_q[0 +: WO];

  // Lookup uses the incoming request in IDLE, the registered request otherwise.
  assign rd_idx     = (state_q == S_IDLE) ? req_idx : q_idx;
  assign rd_wo      = (state_q == S_IDLE) ? req_wo  : q_wo;
  assign lookup_hit = rd_valid && (rd_tag == req_tag);

  cache_line_ram #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG),
    .LINES  (LINES),
    .WORDS  (WORDS)
  ) u_ram (
    .clk_i      (CLK),
    .rst_i      (RST),
    .rd_idx_i   (rd_idx),
    .rd_wo_i    (rd_wo),
    .rd_tag_o   (rd_tag),
    .rd_valid_o (rd_valid),
    .rd_data_o  (rd_data),
    .wr_idx_i   (wr_idx),
    .wr_wo_i    (wr_wo),
    .wr_data_i  (wr_data),
    .data_we_i  (data_we),
    .tag_we_i   (tag_we),
    .wr_tag_i   (q_tag),
    .inval_i    (inval)
  );

  // Next-state, array-write and output decode; reset silences every output.
  always_comb begin
    state_d   = state_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    hit_d     = hit_q;
    miss_d    = miss_q;
    wr_idx    = q_idx;
    wr_wo     = cnt_q;
    wr_data   = mem_rdata;
    data_we   = 1'b0;
    tag_we    = 1'b0;
    inval     = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          waddr_d = req_addr[ADDR_W-1:BO];
          wdata_d = req_wdata;
          wr_idx  = req_idx;
          wr_wo   = req_wo;
          wr_data = req_wdata;
          if (lookup_hit) hit_d  = sat_inc(hit_q);
          else            miss_d = sat_inc(miss_q);
          if (req_we) begin
            data_we = lookup_hit;
            state_d = S_WRITE;
          end else if (lookup_hit) begin
            state_d = S_RESP;
          end else begin
            inval   = 1'b1;
            cnt_d   = '0;
            state_d = S_FILL;
          end
        end
      end
      S_FILL: begin
        mem_req  = 1'b1;
        mem_addr = {q_tag, q_idx, cnt_q, {BO{1'b0}}};
        if (mem_ack) begin
          data_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_WO) begin
            tag_we  = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rd_data;
        state_d   = S_IDLE;
      end
      S_WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {waddr_q, {BO{1'b0}}};
        mem_wdata = wdata_q;
        if (mem_ack) begin
          rsp_valid = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (RST) begin
      data_we   = 1'b0;
      tag_we    = 1'b0;
      inval     = 1'b0;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_rdata = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  // Control state: FSM, fill counter and performance counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  // Registered request payload; meaningful only while a request is in flight.
  always_ff @(posedge CLK) begin
    waddr_q <= waddr_d;
    wdata_q <= wdata_d;
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;

endmodule
